// File: rtl/linebuf_pkg.sv
// Shared types and geometry checks for the line-buffer controller.
package linebuf_pkg;

  // Pixel layout of the default configuration (3 channels x 16 bits).
  localparam int PIX_CHAN = 3;
  localparam int PIX_BITS = 16;
  localparam int PIX_W    = PIX_CHAN * PIX_BITS;

  typedef logic [PIX_W-1:0] pixel_t;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // A stencil needs at least two lines, the frame must be at least as tall
  // as the stencil, and each line needs a write port plus a read port.
  function automatic bit geom_ok(input int lines, input int height, input int ports);
    return (lines >= 2) && (height >= lines) && (ports >= 2);
  endfunction

endpackage

// File: rtl/line_buffer_ctrl_fifo2.sv
// Two-entry registered FIFO carrying finished columns to the output port.
// Write side is a plain push (the caller guarantees space); read side is
// valid/ready. A push together with a pop on a full FIFO is accepted.
module fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data,
  output logic [1:0]   level
);

  logic [1:0]   cnt;
  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         pop;
  logic         push;

  assign pop      = rd_ready && (cnt != 2'd0);
  assign push     = wr_valid && ((cnt != 2'd2) || pop);
  assign rd_valid = (cnt != 2'd0);
  assign rd_data  = slot0;
  assign level    = cnt;

  // Occupancy tracking; the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage: slot0 is always the head, slot1 the entry behind it.
  always_ff @(posedge clk) begin
    if (pop) begin
      slot0 <= slot1;
      if (push && (cnt == 2'd1)) slot0 <= wr_data;
      if (push && (cnt == 2'd2)) slot1 <= wr_data;
    end else if (push) begin
      if (cnt == 2'd0) slot0 <= wr_data;
      else             slot1 <= wr_data;
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer controller: writes raster pixels round-robin into LINES
// single-line SRAMs and, once LINES-1 rows are stored, emits one vertical
// column per accepted pixel. Column packing: row k occupies bits
// [k*CHAN*BITS +: CHAN*BITS], row 0 oldest, row LINES-1 the live pixel.
// Flat SRAM buses: line l, port p sits at slot l*PORTS+p.
module line_buffer_ctrl
  import linebuf_pkg::*;
#(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int LINES  = 3,
  parameter int PORTS  = 2,
  parameter int CHAN   = 3,
  parameter int BITS   = 16,
  parameter int AW     = $clog2(WIDTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CHAN*BITS-1:0]               in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LINES*CHAN*BITS-1:0]         out_col,
  output logic [AW-1:0]                      out_x,
  output logic [$clog2(HEIGHT)-1:0]          out_y,
  output logic                               busy,
  output logic                               frame_done,
  output logic [LINES*PORTS*AW-1:0]          sram_addr,
  output logic [LINES*PORTS-1:0]             sram_wen,
  output logic [LINES*PORTS-1:0]             sram_ren,
  output logic [CHAN*BITS-1:0]               sram_wdata,
  input  logic [LINES*PORTS*CHAN*BITS-1:0]   sram_rdata
);

  localparam int PW = CHAN * BITS;
  localparam int YW = $clog2(HEIGHT);
  localparam int LW = $clog2(LINES);
  localparam int CW = LINES * PW;
  localparam int EW = CW + AW + YW;

  localparam logic [AW-1:0] X_LAST      = AW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(HEIGHT - 1);
  localparam logic [YW-1:0] Y_FILL_LAST = YW'(LINES - 2);
  localparam logic [LW-1:0] L_LAST      = LW'(LINES - 1);

  if (!geom_ok(LINES, HEIGHT, PORTS)) begin : g_bad_geom
    $error("line_buffer_ctrl: unsupported LINES/HEIGHT/PORTS combination");
  end

  state_t          state;
  logic [AW-1:0]   x;
  logic [YW-1:0]   y;
  logic [LW-1:0]   wr_line;

  logic            vld_p0;
  logic            row_end_p0;

  logic            vld_p1;
  logic [AW-1:0]   x_p1;
  logic [YW-1:0]   y_p1;
  logic [LW-1:0]   wl_p1;
  logic [PW-1:0]   pix_p1;
  logic [CW-1:0]   col_p1;

  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head;
  logic            fifo_vld;
  logic [1:0]      level;
  logic            pop;
  logic [2:0]      occ_next;

  // ---- stage p0: acceptance, SRAM write and read issue ----
  assign vld_p0     = in_valid && in_ready;
  assign row_end_p0 = (x == X_LAST);
  assign pop        = out_valid && out_ready;
  // Columns that will be held after this edge, counting the in-flight read.
  assign occ_next   = 3'(level) + 3'(vld_p1) - 3'(pop);

  // Input handshake: open in FILL, throttled by output space in STREAM.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        FILL:    in_ready = 1'b1;
        STREAM:  in_ready = (occ_next < 3'd2);
        default: in_ready = 1'b0;
      endcase
    end
  end

  // SRAM strobes: port 0 of the current line writes, port 1 of every other
  // line reads the same column while streaming.
  always_comb begin
    sram_wen   = '0;
    sram_ren   = '0;
    sram_addr  = '0;
    sram_wdata = in_data;
    if (vld_p0) begin
      for (int l = 0; l < LINES; l++) begin
        if (LW'(l) == wr_line) begin
          sram_wen[l*PORTS]                = 1'b1;
          sram_addr[(l*PORTS)*AW +: AW]    = x;
        end else if (state == STREAM) begin
          sram_ren[l*PORTS+1]              = 1'b1;
          sram_addr[(l*PORTS+1)*AW +: AW]  = x;
        end
      end
    end
  end

  // Frame sequencer and raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      wr_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FILL;
            x       <= '0;
            y       <= '0;
            wr_line <= '0;
          end
        end
        FILL, STREAM: begin
          if (vld_p0) begin
            if (row_end_p0) begin
              x       <= '0;
              y       <= y + 1'b1;
              wr_line <= (wr_line == L_LAST) ? '0 : wr_line + 1'b1;
              if ((state == FILL) && (y == Y_FILL_LAST)) state <= STREAM;
              if ((state == STREAM) && (y == Y_LAST))    state <= DONE;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        DONE: begin
          if ((level == 2'd0) && !vld_p1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: read data returns, column assembled and pushed ----
  // Marks a column whose SRAM reads are in flight.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0 && (state == STREAM);
  end

  // Side information captured alongside the reads.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      x_p1   <= x;
      y_p1   <= y;
      wl_p1  <= wr_line;
      pix_p1 <= in_data;
    end
  end

  // Oldest stored row is the line right after the one just written.
  always_comb begin
    int src;
    src    = 0;
    col_p1 = '0;
    for (int k = 0; k < LINES - 1; k++) begin
      src = int'(wl_p1) + 1 + k;
      if (src >= LINES) src = src - LINES;
      col_p1[k*PW +: PW] = sram_rdata[(src*PORTS+1)*PW +: PW];
    end
    col_p1[(LINES-1)*PW +: PW] = pix_p1;
  end

  assign push_data = {col_p1, x_p1, y_p1};

  fifo2 #(.W(EW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (vld_p1),
    .wr_data  (push_data),
    .rd_valid (fifo_vld),
    .rd_ready (out_ready),
    .rd_data  (head),
    .level    (level)
  );

  // ---- output side ----
  assign out_valid  = fifo_vld && !rst;
  assign out_col    = head[EW-1 -: CW];
  assign out_x      = head[YW +: AW];
  assign out_y      = head[YW-1:0];
  assign busy       = !rst && (state != IDLE);
  assign frame_done = !rst && (state == DONE) && (level == 2'd0) && !vld_p1;

endmodule

// File: doc/line_buffer_ctrl.md
LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 SHALL have parameters: WIDTH, default 1920, pixels per image row.
REQ-002 SHALL have parameters: HEIGHT, default 1080, rows per frame; LINES, default 3, SRAM lines (stencil height).
REQ-003 SHALL have parameters: PORTS, default 2, ports per line; CHAN, default 3, channels per pixel; BITS, default 16, bits per channel; AW, default $clog2(WIDTH), address width.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame-start pulse.
- in_valid/in_ready  in/out  1  input pixel handshake.
- in_data  in  CHAN*BITS  raster-order pixel.
- out_valid/out_ready  out/in  1  output column handshake.
- out_col  out  LINES*CHAN*BITS  vertical column; row 0 oldest, row LINES-1 newest.
- out_x  out  AW  column index of out_col.
- out_y  out  $clog2(HEIGHT)  row index of the newest row.
- busy  out  1  high when state is not IDLE.
- frame_done  out  1  one-cycle pulse.
- sram_addr  out  LINES*PORTS*AW  per-line, per-port address.
- sram_wen  out  LINES*PORTS  write enables.
- sram_ren  out  LINES*PORTS  read enables.
- sram_wdata  out  CHAN*BITS  write data.
- sram_rdata  in  LINES*PORTS*CHAN*BITS  read data, valid one cycle after ren.

Function
REQ-005 SHALL implement states IDLE, FILL, STREAM, DONE: IDLE→FILL on start; FILL→STREAM on acceptance of the last pixel of row LINES-2; STREAM→DONE on acceptance of pixel (WIDTH-1, HEIGHT-1); DONE→IDLE when the output FIFO is empty, with frame_done pulsed that cycle.
REQ-006 SHALL ignore start outside IDLE.
REQ-007 SHALL hold in_ready low in IDLE and DONE.
REQ-008 SHALL accept a pixel when in_valid & in_ready.
REQ-009 SHALL keep counters x (0..WIDTH-1), y (0..HEIGHT-1) and wr_line (0..LINES-1), all zero when entering FILL.
REQ-010 SHALL handle counter wrap as follows: on acceptance at x=WIDTH-1, x→0, y→y+1, wr_line→(wr_line+1) mod LINES; otherwise x→x+1.
REQ-011 SHALL, on acceptance, in the same cycle: assert sram_wen[wr_line][0] with sram_addr[wr_line][0]=x and sram_wdata=in_data; only port 0 ever writes.
REQ-012 SHALL, on acceptance in STREAM, in the same cycle: assert sram_ren[l][1] with sram_addr[l][1]=x for every l≠wr_line; in FILL no reads are issued.
REQ-013 SHALL, one cycle after a STREAM acceptance, push {column, x, y} into a 2-entry output FIFO.
REQ-014 SHALL build the pushed column as: row k (0..LINES-2) = sram_rdata[(wr_line_at_accept+1+k) mod LINES][1]; row LINES-1 = registered in_data.
REQ-015 SHALL set in_ready in FILL to 1.
REQ-016 SHALL set in_ready in STREAM to (FIFO occupancy + in-flight reads) < 2, so no column is ever dropped under back-pressure.
REQ-017 SHALL drive out_valid = FIFO non-empty and out_col/out_x/out_y = FIFO head.
REQ-018 SHALL pop the FIFO on out_valid & out_ready; a simultaneous push and pop on a full FIFO is legal.
REQ-019 SHALL have latency acceptance→out_valid of 2 cycles when the FIFO is empty.
REQ-020 SHALL sustain throughput of 1 column/cycle while out_ready is held high.
REQ-021 SHALL drive sram_wen/sram_ren to 0 on every cycle without acceptance.
REQ-022 SHALL drive unused sram_addr to 0.

Reset
REQ-023 SHALL, on rst high at a clock edge regardless of state (including mid-frame), set: state→IDLE, x/y/wr_line→0, FIFO flushed, in-flight push cancelled.
REQ-024 SHALL, during and after reset, drive out_valid=0, in_ready=0, busy=0, frame_done=0, all sram_wen/ren=0.

Structure
REQ-025 SHALL place pixel_t (CHAN×BITS), the state enum and a LINES≥2 / HEIGHT≥LINES elaboration check in package linebuf_pkg.
REQ-026 SHALL implement the output FIFO as sub-module fifo2 (2-entry, valid/ready, registered storage).

Verification (WIDTH=4, HEIGHT=5, LINES=3, pixel value = 16*y+x)
REQ-027 SHALL cover full frame with out_ready=1: start, stream 20 pixels continuously → exactly 12 columns, out_y 2..4.
- First column is {0x00,0x10,0x20} at x=0, y=2, 2 cycles after pixel 0x20 is accepted.
- frame_done pulses once; busy then falls.
REQ-028 SHALL cover line rotation: at y=3, writes go to line 0.
- Column at (x=1, y=3) = {0x11,0x21,0x31}, i.e. oldest row comes from line 1.
REQ-029 SHALL cover back-pressure: out_ready=0 from y=2 onward → in_ready falls after 2 accepted columns.
- Releasing out_ready delivers all columns in order with no loss or duplication.
REQ-030 SHALL cover FILL behaviour: during the first 8 pixels → no sram_ren, out_valid stays 0, wen on lines 0 then 1.
REQ-031 SHALL cover reset mid-STREAM with 2 FIFO entries: rst for 1 cycle → out_valid=0 and state IDLE next cycle.
- A new start then reproduces the REQ-027 output exactly.
REQ-032 SHALL cover start while busy: pulse start during STREAM → no effect on counters or output.
